sw_serial_rx: RTL

Serial reader for the board's external parallel-in/serial-out switch and button shift-register chain (74HC165-style). It is the reverse of the LED serial writer: it loads the chain, clocks it out MSB first, and delivers the 16-bit word on the `Clk_100M` domain with a valid strobe and a change flag. The line polarity matches the LED link: the line carries inverted data, and the block stores the word un-inverted. It sits beside the LED controller at the top level and feeds switch state to the user logic.

---
 rtl/sw_serial_pkg.sv | 15 +
 rtl/ser_tick_gen.sv | 28 ++
 rtl/sw_serial_rx.sv | 120 ++++++++++++
 3 files changed

// File: rtl/sw_serial_pkg.sv
// Shared types and default constants for the switch/button serial reader.
package sw_serial_pkg;

  localparam int unsigned DEF_WIDTH   = 16;
  localparam int unsigned DEF_CLK_DIV = 50;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

endpackage

// File: rtl/ser_tick_gen.sv
// Half-period counter: tick_o marks the last cycle of a CLK_DIV-cycle window.
module ser_tick_gen #(
  parameter int unsigned CLK_DIV = 50
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sw_serial_rx.sv
// Reads a 74HC165-style PISO chain MSB first and presents the un-inverted word
// with a valid strobe and a changed flag.
module sw_serial_rx
  import sw_serial_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic             Clk_100M,
  input  logic             reset,
  input  logic             start,
  input  logic             ser_di,
  output logic             ser_clk,
  output logic             ser_pl_n,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  output logic             changed,
  output logic             busy,
  output state_e           state_dbg
);

  localparam int unsigned BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [1:0]       sync_q;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             valid_q, valid_d;
  logic             changed_q, changed_d;
  logic             ser_clk_q, ser_clk_d;
  logic             ser_pl_n_q, ser_pl_n_d;
  logic             tick;
  logic             tick_clr;
  logic             sample;
  logic             di_sync;

  // Clearing on every state change makes each state last exactly CLK_DIV cycles.
  assign tick_clr = (state_q == ST_IDLE) || (state_d != state_q);

  ser_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_i  (Clk_100M),
    .rst_ni (reset),
    .clr_i  (tick_clr),
    .tick_o (tick)
  );

  assign di_sync = sync_q[1];
  assign sample  = (state_q == ST_SHIFT_LO) && tick;

  always_ff @(posedge Clk_100M or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (start) state_d = ST_LOAD;
      ST_LOAD:     if (tick) state_d = ST_SHIFT_LO;
      ST_SHIFT_LO: if (tick) state_d = (bit_cnt_q == LAST_BIT) ? ST_DONE : ST_SHIFT_HI;
      ST_SHIFT_HI: if (tick) state_d = ST_SHIFT_LO;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so pins change with the state.
  always_comb begin
    ser_clk_d  = (state_d == ST_SHIFT_HI);
    ser_pl_n_d = (state_d != ST_LOAD);
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    changed_d  = 1'b0;
    if (state_q == ST_LOAD) bit_cnt_d = '0;
    if (sample) begin
      shreg_d   = {shreg_q[WIDTH-2:0], ~di_sync};
      bit_cnt_d = bit_cnt_q + 1'b1;
      if (bit_cnt_q == LAST_BIT) begin
        data_d    = shreg_d;
        valid_d   = 1'b1;
        changed_d = (shreg_d != data_q);
      end
    end
  end

  always_ff @(posedge Clk_100M or negedge reset) begin
    if (!reset) begin
      sync_q     <= 2'b00;
      shreg_q    <= '0;
      data_q     <= '0;
      bit_cnt_q  <= '0;
      valid_q    <= 1'b0;
      changed_q  <= 1'b0;
      ser_clk_q  <= 1'b0;
      ser_pl_n_q <= 1'b1;
    end else begin
      sync_q     <= {sync_q[0], ser_di};
      shreg_q    <= shreg_d;
      data_q     <= data_d;
      bit_cnt_q  <= bit_cnt_d;
      valid_q    <= valid_d;
      changed_q  <= changed_d;
      ser_clk_q  <= ser_clk_d;
      ser_pl_n_q <= ser_pl_n_d;
    end
  end

  assign ser_clk    = ser_clk_q;
  assign ser_pl_n   = ser_pl_n_q;
  assign data       = data_q;
  assign data_valid = valid_q;
  assign changed    = changed_q;
  assign busy       = (state_q != ST_IDLE);
  assign state_dbg  = state_q;

endmodule
